uart_tx_arb: RTL and testbench

Four-client round-robin arbiter that shares one UART byte transmitter among independent requesters, such as the echo path, the status reporter and the command-response path. It sits between the clients and the transmitter. It captures the granted client's byte, launches the transmitter with a one-cycle start pulse and tracks the transmitter's busy flag until the frame completes. A per-client lock keeps the grant across multi-byte messages so that messages from different clients never interleave on the serial line.

---
 rtl/uart_tx_arb.sv | 126 ++++++++++++
 tb/tb_uart_tx_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: four-client round-robin arbiter in front of a single UART byte
// transmitter. Launches the transmitter with a one-cycle start pulse, follows
// tx_busy through the frame, and can hold the grant across locked multi-byte
// messages so that messages from different clients never interleave.
module uart_tx_arb #(
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [31:0] din,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [3:0]  ack,
    output logic        grant_vld,
    output logic [1:0]  grant_id,
    output logic        timeout_err
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic [7:0]       w_win_byte;
    logic [7:0]       w_own_byte;

    // Round-robin search starting at r_ptr; the lowest offset with req set wins.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Byte lanes of the new winner and of the current owner (for locked reloads).
    always_comb begin
        w_win_byte = din[{w_win, 3'b000} +: 8];
        w_own_byte = din[{grant_id, 3'b000} +: 8];
    end

    // Arbitration FSM with registered transmitter and client handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            ack         <= 4'b0000;
            grant_vld   <= 1'b0;
            grant_id    <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            ack         <= 4'b0000;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        tx_data   <= w_win_byte;
                        grant_id  <= w_win;
                        grant_vld <= 1'b1;
                        tx_start  <= 1'b1;
                        ack       <= 4'b0001 << w_win;
                        r_cnt     <= '0;
                        r_state   <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= WAIT_LO;
                    end else begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                        // Transmitter never acknowledged the launch: give up the grant.
                        if (r_cnt == CNT_LAST) begin
                            timeout_err <= 1'b1;
                            grant_vld   <= 1'b0;
                            r_ptr       <= grant_id + 2'd1;
                            r_state     <= IDLE;
                        end
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (lock[grant_id] && req[grant_id]) begin
                            tx_data  <= w_own_byte;
                            tx_start <= 1'b1;
                            ack      <= 4'b0001 << grant_id;
                            r_cnt    <= '0;
                            r_state  <= WAIT_HI;
                        end else begin
                            grant_vld <= 1'b0;
                            r_ptr     <= grant_id + 2'd1;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scoreboard bench for uart_tx_arb. Client and
// transmitter models drive the DUT; every launch is checked against a queue
// of hand-computed expected grants (client, byte, cycles since last launch).
module tb_uart_tx_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] din;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  ack;
    logic        grant_vld;
    logic [1:0]  grant_id;
    logic        timeout_err;

    uart_tx_arb #(.BUSY_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .lock        (lock),
        .din         (din),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ack         (ack),
        .grant_vld   (grant_vld),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int id;
        int b;
        int gap;   // 0: launch spacing not checked
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    int       n_cmp;
    int       n_err;
    int       to_cnt;
    int       cyc;
    int       busy_len;
    bit       busy_en;
    logic [3:0] lock_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int id, input int b, input int gap);
        exp_t e;
        e.id = id;
        e.b = b;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic cpush(input int i, input logic [7:0] b);
        case (i)
            0: q0.push_back(b);
            1: q1.push_back(b);
            2: q2.push_back(b);
            default: q3.push_back(b);
        endcase
    endtask

    function automatic bit is_idle();
        return (sb.size() == 0) && !grant_vld && !tx_busy &&
               (q0.size() == 0) && (q1.size() == 0) &&
               (q2.size() == 0) && (q3.size() == 0);
    endfunction

    // Clients: present the head byte while queued, pop it on ack.
    task automatic client_drv();
        req  = 4'b0000;
        lock = 4'b0000;
        din  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (ack[0] && q0.size() > 0) void'(q0.pop_front());
            if (ack[1] && q1.size() > 0) void'(q1.pop_front());
            if (ack[2] && q2.size() > 0) void'(q2.pop_front());
            if (ack[3] && q3.size() > 0) void'(q3.pop_front());
            req = {q3.size() > 0, q2.size() > 0, q1.size() > 0, q0.size() > 0};
            din = {(q3.size() > 0) ? q3[0] : 8'h00, (q2.size() > 0) ? q2[0] : 8'h00,
                   (q1.size() > 0) ? q1[0] : 8'h00, (q0.size() > 0) ? q0[0] : 8'h00};
            lock = lock_en & req;
        end
    endtask

    // Transmitter: busy rises right after tx_start and stays high busy_len cycles.
    task automatic busy_model();
        int bcnt;
        bcnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                tx_busy = 1'b0;
                bcnt = 0;
            end else if (tx_start && busy_en) begin
                tx_busy = 1'b1;
                bcnt = busy_len;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
        end
    endtask

    // Scoreboard monitor: every launch pops one expected grant.
    task automatic monitor();
        int prev_start;
        int gap;
        exp_t e;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                gap = cyc - prev_start;
                prev_start = cyc;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_launch: got client %0d byte 0x%0h expected none",
                             grant_id, tx_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ack", 32'(ack), 32'(1 << e.id));
                    chk("sb_data", 32'(tx_data), 32'(e.b));
                    chk("sb_grant_id", 32'(grant_id), 32'(e.id));
                    chk("sb_grant_vld", 32'(grant_vld), 32'd1);
                    if (e.gap != 0) chk("sb_gap", 32'(gap), 32'(e.gap));
                end
            end
            if (rst_n && timeout_err) to_cnt++;
        end
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (!is_idle() && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(is_idle()), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_start(input int maxc, output int t);
        int k;
        k = 0;
        while (!tx_start && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", 32'(tx_start), 32'd1);
        t = cyc;
    endtask

    initial begin
        int k;
        int t1;
        n_cmp = 0;
        n_err = 0;
        to_cnt = 0;
        rst_n = 1'b0;
        busy_len = 100;
        busy_en = 1'b1;
        lock_en = 4'b0000;
        fork
            client_drv();
            busy_model();
            monitor();
        join_none

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);

        // Single request, one-cycle latency, grant released after busy falls.
        cpush(0, 8'h55);
        push_exp(0, 8'h55, 0);
        @(negedge clk);
        chk("t1_no_start_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("t1_latency", 32'(tx_start), 32'd1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx_busy && k < 200);
        chk("t1_busy_fell", 32'(tx_busy), 32'd0);
        chk("t1_gv_hold", 32'(grant_vld), 32'd1);
        @(negedge clk);
        chk("t1_gv_fall", 32'(grant_vld), 32'd0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        busy_len = 10;

        // All four at once: 0,1,2,3 then client 0's second byte.
        cpush(0, 8'h10); cpush(0, 8'h11);
        cpush(1, 8'h20); cpush(2, 8'h30); cpush(3, 8'h40);
        push_exp(0, 8'h10, 0);
        push_exp(1, 8'h20, 12);
        push_exp(2, 8'h30, 12);
        push_exp(3, 8'h40, 12);
        push_exp(0, 8'h11, 12);
        wait_idle(400);
        cpush(0, 8'h12); cpush(0, 8'h13);
        push_exp(0, 8'h12, 0);
        push_exp(0, 8'h13, 12);
        wait_idle(400);

        // Locked message on client 2 completes before waiting client 0.
        lock_en = 4'b0100;
        cpush(2, 8'hA1); cpush(2, 8'hA2); cpush(2, 8'hA3);
        cpush(0, 8'hB0);
        push_exp(2, 8'hA1, 0);
        push_exp(2, 8'hA2, 11);
        push_exp(2, 8'hA3, 11);
        push_exp(0, 8'hB0, 12);
        wait_idle(400);
        lock_en = 4'b0000;

        // Pointer wrap 3 -> 0.
        cpush(3, 8'hC3);
        push_exp(3, 8'hC3, 0);
        wait_idle(400);
        cpush(0, 8'hC0); cpush(3, 8'hC4);
        push_exp(0, 8'hC0, 0);
        push_exp(3, 8'hC4, 12);
        wait_idle(400);

        // Busy never rises: timeout after 16 cycles, then pending client 2.
        busy_en = 1'b0;
        cpush(1, 8'hD1); cpush(2, 8'hD2);
        push_exp(1, 8'hD1, 0);
        push_exp(2, 8'hD2, 17);
        wait_start(10, t1);
        k = 0;
        while (!timeout_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t5_timeout_seen", 32'(timeout_err), 32'd1);
        chk("t5_timeout_cycle", 32'(cyc - t1), 32'd16);
        chk("t5_gv_dropped", 32'(grant_vld), 32'd0);
        busy_en = 1'b1;
        @(negedge clk);
        chk("t5_timeout_width", 32'(timeout_err), 32'd0);
        wait_idle(400);

        // Reset in WAIT_LO clears outputs at once and restarts from client 0.
        busy_len = 40;
        cpush(1, 8'hE1);
        push_exp(1, 8'hE1, 0);
        wait_start(10, t1);
        repeat (5) @(negedge clk);
        chk("t6_grant_held", 32'(grant_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear",
            32'({tx_start, ack, grant_vld, grant_id, tx_data, timeout_err}), 32'd0);
        cpush(0, 8'hF0); cpush(3, 8'hF3);
        push_exp(0, 8'hF0, 0);
        push_exp(3, 8'hF3, 42);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(400);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("timeout_pulses", 32'(to_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
